// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first as a + ~b + 1,
// one bit per clock, framed by a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   diff,
   output logic             borrow
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   nb_sh_q, nb_sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH:0]     diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               done_q, done_d;
   logic               sum_s;
   logic               carry_s;

   // One full-adder slice on the current LSBs of the operand shifters.
   always_comb begin
      sum_s   = a_sh_q[0] ^ nb_sh_q[0] ^ carry_q;
      carry_s = (a_sh_q[0] & nb_sh_q[0]) | (a_sh_q[0] & carry_q) | (nb_sh_q[0] & carry_q);
   end

   // Next-state and datapath update for the IDLE/SHIFT controller.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      nb_sh_d  = nb_sh_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SHIFT;
               a_sh_d   = a;
               nb_sh_d  = ~b;
               carry_d  = 1'b1;
               cnt_d    = '0;
               diff_d   = '0;
               borrow_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // Sum bits enter from the top so the first (LSB) one settles at bit 0.
            diff_d  = {diff_q[WIDTH], sum_s, diff_q[WIDTH-1:1]};
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            nb_sh_d = {1'b0, nb_sh_q[WIDTH-1:1]};
            carry_d = carry_s;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d        = IDLE;
               diff_d[WIDTH]  = ~carry_s;
               borrow_d       = ~carry_s;
               done_d         = 1'b1;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         nb_sh_q  <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         nb_sh_q  <= nb_sh_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model checked every
// cycle, directed cases with literal results, exhaustive back-to-back and random phases.
module tb_serial_subtractor;

   localparam int W = 5;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W:0]   diff;
   logic         borrow;

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op keeps the unit busy for W cycles, then
   // presents a - b (computed directly) with a one-cycle done.
   int         m_left;
   logic       m_done;
   logic [W:0] m_diff;
   logic       m_borrow;
   logic [W:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left   <= 0;
         m_done   <= 1'b0;
         m_diff   <= '0;
         m_borrow <= 1'b0;
         m_pend   <= '0;
      end else if (m_left == 0 && start) begin
         m_left   <= W;
         m_done   <= 1'b0;
         m_diff   <= '0;
         m_borrow <= 1'b0;
         m_pend   <= {1'b0, a} - {1'b0, b};
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done   <= 1'b1;
            m_diff   <= m_pend;
            m_borrow <= m_pend[W];
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   // Per-cycle comparison against the model; diff is only meaningful when not busy.
   always @(negedge clk) begin
      check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("busy_and_done", {31'd0, busy & done}, 32'd0);
      if (!busy && !(m_left > 0)) begin
         check("diff", {26'd0, diff}, {26'd0, m_diff});
         check("borrow", {31'd0, borrow}, {31'd0, m_borrow});
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   // Wait (bounded) for done; return how many busy negedges preceded it.
   task automatic wait_done(output int n, output bit seen);
      seen = 1'b0;
      n    = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done within 20 cycles");
      end
   endtask

   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        output logic [W:0] rd, output logic rb);
      int  n;
      bit  seen;
      step();
      a = ta; b = tb_v; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n, seen);
      check("latency", n, W);
      rd = diff;
      rb = borrow;
   endtask

   initial begin
      logic [W:0] rd;
      logic       rb;
      int         n;
      bit         seen;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_diff", {26'd0, diff}, 32'd0);
      check("rst_borrow", {31'd0, borrow}, 32'd0);
      step();
      rst_n = 1'b1;

      do_op(5'd5, 5'd3, rd, rb);
      check("d5m3_diff", {26'd0, rd}, {26'd0, 6'b000010});
      check("d5m3_borrow", {31'd0, rb}, 32'd0);
      do_op(5'd3, 5'd5, rd, rb);
      check("d3m5_diff", {26'd0, rd}, {26'd0, 6'b111110});
      check("d3m5_borrow", {31'd0, rb}, 32'd1);
      do_op(5'd0, 5'd31, rd, rb);
      check("d0m31_diff", {26'd0, rd}, {26'd0, 6'b100001});
      check("d0m31_borrow", {31'd0, rb}, 32'd1);
      do_op(5'd31, 5'd0, rd, rb);
      check("d31m0_diff", {26'd0, rd}, 32'd31);
      check("d31m0_borrow", {31'd0, rb}, 32'd0);

      // Start while busy is ignored; start in the done cycle is accepted.
      step();
      a = 5'd7; b = 5'd2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      a = 5'd1; b = 5'd1; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n, seen);
      check("ign_latency", n, W - 2);
      check("ign_diff", {26'd0, diff}, 32'd5);
      a = 5'd9; b = 5'd9; start = 1'b1;
      step();
      start = 1'b0;
      wait_done(n, seen);
      check("indone_latency", n, W);
      check("indone_diff", {26'd0, diff}, 32'd0);
      check("indone_borrow", {31'd0, borrow}, 32'd0);

      // Reset mid-operation aborts with no done.
      step();
      a = 5'd20; b = 5'd4; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_diff", {26'd0, diff}, 32'd0);
      check("abort_borrow", {31'd0, borrow}, 32'd0);
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", {31'd0, seen}, 32'd0);
      do_op(5'd4, 5'd20, rd, rb);
      check("d4m20_diff", {26'd0, rd}, {26'd0, 6'b110000});
      check("d4m20_borrow", {31'd0, rb}, 32'd1);

      // Exhaustive back-to-back: start held high, next operands staged while busy.
      step();
      a = 5'd0; b = 5'd0; start = 1'b1;
      step();
      for (int i = 0; i < 1024; i++) begin
         logic [W:0] exp_d;
         exp_d = {1'b0, a} - {1'b0, b};
         if (i == 1023) begin
            start = 1'b0;
         end else begin
            a = W'((i + 1) >> W);
            b = W'((i + 1) & 31);
         end
         wait_done(n, seen);
         check("ex_spacing", n, W);
         check("ex_diff", {26'd0, diff}, {26'd0, exp_d});
         check("ex_borrow", {31'd0, borrow}, {31'd0, exp_d[W]});
         step();
      end

      // Randomised phase: random start, operands and occasional reset.
      for (int i = 0; i < 600; i++) begin
         a     = W'($urandom_range(0, 31));
         b     = W'($urandom_range(0, 31));
         start = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 60) != 0);
         step();
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
